// File: rtl/cdic_audio_sample_player.sv
// cdic_audio_sample_player: buffers decoded stereo PCM pairs in a small FIFO
// and releases one pair per selected sample tick (37.8 kHz or 44.1 kHz).
// Optional feature macro: CDIC_PLAYER_HOLD_ON_UNDERRUN_EN
//   defined   -> an underrun repeats the last played sample
//   undefined -> an underrun outputs silence (zero) until the next pop
module cdic_audio_sample_player #(
  parameter int DEPTH    = 16,
  parameter int SAMPLE_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_tick37,
  input  logic                     sample_tick44,
  input  logic                     enable,
  input  logic                     rate_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SAMPLE_W-1:0]      in_left,
  input  logic [SAMPLE_W-1:0]      in_right,
  output logic [SAMPLE_W-1:0]      out_left,
  output logic [SAMPLE_W-1:0]      out_right,
  output logic                     out_strobe,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] HALF_LVL = CW'(DEPTH / 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rate_q, rate_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [SAMPLE_W-1:0]   out_left_q, out_left_d;
  logic [SAMPLE_W-1:0]   out_right_q, out_right_d;
  logic                  strobe_q, strobe_d;
  logic                  underrun_q, underrun_d;

  // Left channel in the upper half, right channel in the lower half.
  logic [2*SAMPLE_W-1:0] mem_q [DEPTH];
  logic [2*SAMPLE_W-1:0] head;
  logic                  push_en;
  logic                  pop;
  logic                  tick_sel;

  // in_ready looks only at registered state so a same-cycle pop never
  // reopens a full FIFO early; a push while enable is low is dropped.
  assign in_ready = (state_q != ST_IDLE) && (count_q != FULL_LVL);
  assign push_en  = in_valid && in_ready && enable;
  assign tick_sel = rate_q ? sample_tick44 : sample_tick37;
  assign head     = mem_q[rd_ptr_q];

  // Sample storage; the output registers act as the registered read port.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= {in_left, in_right};
    end
  end

  // Next-state logic: play FSM, pointer/occupancy bookkeeping, output sample.
  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    strobe_d    = 1'b0;
    underrun_d  = underrun_q;
    pop         = 1'b0;

    if (!enable) begin
      // Disable flushes everything, including a tick or push this cycle.
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_left_d  = '0;
      out_right_d = '0;
      underrun_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rate_d  = rate_sel;
          state_d = ST_PRIME;
        end
        ST_PRIME: begin
          // Ticks are ignored here, including the one in the cycle the
          // half-full threshold is first seen.
          if (count_q >= HALF_LVL) begin
            state_d = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick_sel) begin
            strobe_d = 1'b1;
            if (count_q != '0) begin
              pop         = 1'b1;
              out_left_d  = head[2*SAMPLE_W-1:SAMPLE_W];
              out_right_d = head[SAMPLE_W-1:0];
              rd_ptr_d    = rd_ptr_q + AW'(1);
            end else begin
              underrun_d = 1'b1;
              state_d    = ST_PRIME;
`ifdef CDIC_PLAYER_HOLD_ON_UNDERRUN_EN
              out_left_d  = out_left_q;
              out_right_d = out_right_q;
`else
              out_left_d  = '0;
              out_right_d = '0;
`endif
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (push_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end

      if (push_en && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push_en) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rate_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
    end
  end

  assign out_left   = out_left_q;
  assign out_right  = out_right_q;
  assign out_strobe = strobe_q;
  assign underrun   = underrun_q;
  assign fill_level = count_q;

endmodule

// File: tb/tb_cdic_audio_sample_player.sv
// Directed bench for cdic_audio_sample_player (DEPTH 16) with a scoreboard
// queue of pushed sample pairs that is popped on every expected out_strobe.
module tb_cdic_audio_sample_player;

  localparam int DEPTH = 16;
  localparam int SW    = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sample_tick37;
  logic          sample_tick44;
  logic          enable;
  logic          rate_sel;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_left;
  logic [SW-1:0] in_right;
  logic [SW-1:0] out_left;
  logic [SW-1:0] out_right;
  logic          out_strobe;
  logic          underrun;
  logic [4:0]    fill_level;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_q[$];
  logic [31:0] last_pair = 32'h0;

  cdic_audio_sample_player #(.DEPTH(DEPTH), .SAMPLE_W(SW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_tick37(sample_tick37),
    .sample_tick44(sample_tick44),
    .enable       (enable),
    .rate_sel     (rate_sel),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_left      (in_left),
    .in_right     (in_right),
    .out_left     (out_left),
    .out_right    (out_right),
    .out_strobe   (out_strobe),
    .underrun     (underrun),
    .fill_level   (fill_level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Offer one pair until accepted (bounded), recording it on acceptance.
  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    bit done = 1'b0;
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    for (int i = 0; i < 32 && !done; i++) begin
      if (in_ready === 1'b1) begin
        sb_q.push_back({l, r});
        done = 1'b1;
      end
      cyc();
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      push_pair(16'($urandom()) | 16'h0001, 16'($urandom()) | 16'h8000);
    end
  endtask

  // One tick cycle, then check strobe and (if a pop is expected) the data.
  task automatic tick(input bit t37, input bit t44, input bit exp_pop, input string tag);
    logic [31:0] exp;
    sample_tick37 = t37;
    sample_tick44 = t44;
    cyc();
    sample_tick37 = 1'b0;
    sample_tick44 = 1'b0;
    if (exp_pop) begin
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      check({tag, "_strobe"}, 32'(out_strobe), 32'd1);
      check({tag, "_data"}, {out_left, out_right}, exp);
      last_pair = exp;
    end else begin
      check({tag, "_nostrobe"}, 32'(out_strobe), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] exp_pair;
    logic [31:0] under_pair;

    reset_n       = 1'b0;
    enable        = 1'b0;
    rate_sel      = 1'b0;
    sample_tick37 = 1'b0;
    sample_tick44 = 1'b0;
    in_valid      = 1'b0;
    in_left       = '0;
    in_right      = '0;
    repeat (3) cyc();

    // Reset values
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_strobe", 32'(out_strobe), 32'd0);
    check("rst_out", {out_left, out_right}, 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);

    reset_n = 1'b1;
    cyc();
    check("idle_ready", 32'(in_ready), 32'd0);

    // Enable at 37.8 kHz and prime with 8 pairs
    enable = 1'b1;
    cyc();
    check("prime_ready", 32'(in_ready), 32'd1);
    tick(1'b1, 1'b0, 1'b0, "prime_tick");
    push_n(8);
    check("prime_fill", 32'(fill_level), 32'd8);
    cyc();

    // PLAY: wrong-rate tick ignored, right-rate ticks pop in order
    tick(1'b0, 1'b1, 1'b0, "t44_ignored");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, "pop37");
    cyc();
    check("strobe_single", 32'(out_strobe), 32'd0);
    check("fill_after3", 32'(fill_level), 32'd5);

    // Push and pop in the same cycle at fill level 5
    exp_pair      = sb_q.pop_front();
    in_left       = 16'h7F01;
    in_right      = 16'h80F2;
    in_valid      = 1'b1;
    sample_tick37 = 1'b1;
    sb_q.push_back({16'h7F01, 16'h80F2});
    cyc();
    in_valid      = 1'b0;
    sample_tick37 = 1'b0;
    check("pushpop_strobe", 32'(out_strobe), 32'd1);
    check("pushpop_data", {out_left, out_right}, exp_pair);
    check("pushpop_fill", 32'(fill_level), 32'd5);
    last_pair = exp_pair;

    // rate_sel change during PLAY has no effect
    rate_sel = 1'b1;
    tick(1'b0, 1'b1, 1'b0, "ratechg_t44");
    tick(1'b1, 1'b0, 1'b1, "ratechg_t37");

    // Fill to full without ticks
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready !== 1'b1) break;
      in_left  = 16'(16'h2000 + i);
      in_right = 16'(16'hC000 - i);
      sb_q.push_back({in_left, in_right});
      cyc();
    end
    in_valid = 1'b0;
    check("full_fill", 32'(fill_level), 32'd16);
    check("full_ready", 32'(in_ready), 32'd0);
    tick(1'b1, 1'b0, 1'b1, "pop_full");
    check("ready_after_pop", 32'(in_ready), 32'd1);
    check("fill_after_pop", 32'(fill_level), 32'd15);

    // Drain, then one more tick underruns
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick(1'b1, 1'b0, 1'b1, "drain");
`ifdef CDIC_PLAYER_HOLD_ON_UNDERRUN_EN
    under_pair = last_pair;
`else
    under_pair = 32'h0;
`endif
    sample_tick37 = 1'b1;
    cyc();
    sample_tick37 = 1'b0;
    check("ur_strobe", 32'(out_strobe), 32'd1);
    check("ur_flag", 32'(underrun), 32'd1);
    check("ur_data", {out_left, out_right}, under_pair);
    check("ur_fill", 32'(fill_level), 32'd0);
    cyc();
    check("ur_strobe_drop", 32'(out_strobe), 32'd0);
    check("ur_sticky", 32'(underrun), 32'd1);
    check("ur_prime_ready", 32'(in_ready), 32'd1);
    tick(1'b1, 1'b0, 1'b0, "ur_prime_tick");
    check("ur_hold_data", {out_left, out_right}, under_pair);

    // Drop enable: flush and clear
    enable = 1'b0;
    cyc();
    check("dis_underrun", 32'(underrun), 32'd0);
    check("dis_fill", 32'(fill_level), 32'd0);
    check("dis_ready", 32'(in_ready), 32'd0);
    check("dis_out", {out_left, out_right}, 32'd0);
    sb_q.delete();

    // Re-enable with rate_sel = 1 latched
    enable = 1'b1;
    cyc();
    push_n(8);
    cyc();
    tick(1'b1, 1'b0, 1'b0, "r1_t37_ignored");
    tick(1'b0, 1'b1, 1'b1, "r1_t44");

    // Tick coinciding with enable falling is ignored
    enable        = 1'b0;
    sample_tick44 = 1'b1;
    cyc();
    sample_tick44 = 1'b0;
    check("dis_tick_strobe", 32'(out_strobe), 32'd0);
    check("dis_tick_out", {out_left, out_right}, 32'd0);
    check("dis_tick_fill", 32'(fill_level), 32'd0);
    sb_q.delete();

    // Asynchronous reset mid-PLAY, between clock edges
    enable = 1'b1;
    cyc();
    push_n(8);
    cyc();
    tick(1'b0, 1'b1, 1'b1, "pre_reset_pop");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_out", {out_left, out_right}, 32'd0);
    check("async_fill", 32'(fill_level), 32'd0);
    check("async_ready", 32'(in_ready), 32'd0);
    check("async_strobe", 32'(out_strobe), 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
